// File: rtl/sq_pkg.sv
// -----------------------------------------------------------------------------
// sq_pkg
// Shared definitions for the submission-queue burst reader:
//   - sq_state_e   : 2-bit FSM state encoding (IDLE, WAIT_DATA, STREAM, DONE)
//   - SQ_MAX_LEN   : default largest legal burst in beats
//   - SQ_LEN_WIDTH : width of burst length and beat counters
//   - len_is_illegal() : request length legality check
// No ports (package).
// -----------------------------------------------------------------------------
package sq_pkg;

    localparam int SQ_MAX_LEN   = 256;
    localparam int SQ_LEN_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        STREAM    = 2'd2,
        DONE      = 2'd3
    } sq_state_e;

    // A zero-length burst or one longer than max_len is rejected without
    // touching the FIFO.
    function automatic logic len_is_illegal(input logic [SQ_LEN_WIDTH-1:0] len,
                                            input int                      max_len);
        return (len == '0) || (int'(len) > max_len);
    endfunction

endpackage

// File: rtl/sq_burst_reader_if.sv
// -----------------------------------------------------------------------------
// sq_burst_reader_if
// Bundles the three channels around the burst reader:
//   request : req_valid, req_ready, req_len
//   FIFO    : data_count, fifo_empty, data_from_fifo (FWFT head), fifo_pop
//   stream  : m_tdata, m_tvalid, m_tready, m_tlast
// Modports:
//   master : the burst reader (drives req_ready, fifo_pop and the stream)
//   slave  : the surrounding logic (requester, FIFO, stream sink)
// -----------------------------------------------------------------------------
interface sq_burst_reader_if
    import sq_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 15
) ();

    logic                    req_valid;
    logic                    req_ready;
    logic [SQ_LEN_WIDTH-1:0] req_len;

    logic [COUNT_WIDTH-1:0]  data_count;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   data_from_fifo;
    logic                    fifo_pop;

    logic [DATA_WIDTH-1:0]   m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic                    m_tlast;

    modport master (
        input  req_valid, req_len,
        output req_ready,
        input  data_count, fifo_empty, data_from_fifo,
        output fifo_pop,
        output m_tdata, m_tvalid, m_tlast,
        input  m_tready
    );

    modport slave (
        output req_valid, req_len,
        input  req_ready,
        output data_count, fifo_empty, data_from_fifo,
        input  fifo_pop,
        input  m_tdata, m_tvalid, m_tlast,
        output m_tready
    );

endinterface

// File: rtl/sq_axis_out_reg.sv
// -----------------------------------------------------------------------------
// sq_axis_out_reg
// Single-entry registered AXI4-Stream output stage.
// Ports:
//   aclk, reset        : clock, synchronous active-high reset
//   load               : capture load_data/load_last this cycle
//   load_data/load_last: next beat to present
//   tready             : downstream ready
//   tvalid/tdata/tlast : registered stream outputs
// A loaded beat is held unchanged until it is accepted. The caller only
// asserts load when the register is empty or its beat is being accepted in
// the same cycle, so a stalled beat is never overwritten.
// -----------------------------------------------------------------------------
module sq_axis_out_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  tready,
    output logic                  tvalid,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  tlast
);

    logic                  tvalid_q, tvalid_d;
    logic [DATA_WIDTH-1:0] tdata_q,  tdata_d;
    logic                  tlast_q,  tlast_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // block leaves it unassigned; that is what keeps latches from appearing.
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = load_data;
            tlast_d  = load_last;
        end else if (tvalid_q && tready) begin
            // Beat accepted and nothing behind it: empty the register.
            // tdata keeps its last value; only tvalid qualifies it.
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values, independent of statement order or other blocks.
        if (reset) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
        end else begin
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
        end
    end

    assign tvalid = tvalid_q;
    assign tdata  = tdata_q;
    assign tlast  = tlast_q;

endmodule

// File: rtl/sq_burst_reader.sv
// -----------------------------------------------------------------------------
// sq_burst_reader
// Drain side of the SQ data FIFO. Accepts a burst request of N beats, waits
// until the FIFO holds at least N words, then pops exactly N words and
// presents them as a registered AXI4-Stream burst with tlast on beat N.
// Ports:
//   aclk, reset : clock, synchronous active-high reset
//   bus         : sq_burst_reader_if.master (request, FIFO and stream channels)
//   busy        : high from request accept through the done cycle
//   done        : one-cycle pulse at burst completion
//   len_err     : one-cycle pulse with done when req_len was illegal
// -----------------------------------------------------------------------------
module sq_burst_reader
    import sq_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_LEN     = SQ_MAX_LEN,
    parameter int COUNT_WIDTH = 15
) (
    input  logic              aclk,
    input  logic              reset,
    sq_burst_reader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              len_err
);

    localparam logic [SQ_LEN_WIDTH-1:0] LEN_ONE = SQ_LEN_WIDTH'(1);

    sq_state_e               state_q,     state_d;
    logic [SQ_LEN_WIDTH-1:0] len_q,       len_d;
    logic                    err_q,       err_d;
    logic [SQ_LEN_WIDTH-1:0] pop_left_q,  pop_left_d;  // words still to pop
    logic [SQ_LEN_WIDTH-1:0] beat_left_q, beat_left_d; // beats still to hand over

    logic                    req_ready_c;
    logic                    load;
    logic                    load_last;
    logic                    tvalid;
    logic                    tlast;
    logic [DATA_WIDTH-1:0]   tdata;
    logic                    accept;

    assign accept    = tvalid && bus.m_tready;
    assign load_last = (pop_left_q == LEN_ONE);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        err_d       = err_q;
        pop_left_d  = pop_left_q;
        beat_left_d = beat_left_q;
        req_ready_c = 1'b0;
        load        = 1'b0;
        done        = 1'b0;
        len_err     = 1'b0;

        case (state_q)
            IDLE: begin
                // Held low while reset is asserted even though the state
                // register may already read IDLE.
                req_ready_c = !reset;
                if (bus.req_valid && req_ready_c) begin
                    len_d   = bus.req_len;
                    err_d   = len_is_illegal(bus.req_len, MAX_LEN);
                    state_d = err_d ? DONE : WAIT_DATA;
                end
            end

            WAIT_DATA: begin
                if (bus.data_count >= COUNT_WIDTH'(len_q)) begin
                    state_d     = STREAM;
                    pop_left_d  = len_q;
                    beat_left_d = len_q;
                end
            end

            STREAM: begin
                // Pop only when a word is really at the head (fifo_empty wins
                // over data_count) and the output register can take it. A pop
                // in a reset cycle would lose the word, so reset blocks it.
                load = (pop_left_q != '0) && !bus.fifo_empty &&
                       (!tvalid || bus.m_tready) && !reset;
                if (load) begin
                    pop_left_d = pop_left_q - LEN_ONE;
                end
                if (accept) begin
                    beat_left_d = beat_left_q - LEN_ONE;
                    if (tlast) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                len_err = err_q;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            err_q       <= 1'b0;
            pop_left_q  <= '0;
            beat_left_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            err_q       <= err_d;
            pop_left_q  <= pop_left_d;
            beat_left_q <= beat_left_d;
        end
    end

    sq_axis_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .aclk      (aclk),
        .reset     (reset),
        .load      (load),
        .load_data (bus.data_from_fifo),
        .load_last (load_last),
        .tready    (bus.m_tready),
        .tvalid    (tvalid),
        .tdata     (tdata),
        .tlast     (tlast)
    );

    assign busy          = (state_q != IDLE);
    assign bus.req_ready = req_ready_c;
    assign bus.fifo_pop  = load;
    assign bus.m_tvalid  = tvalid;
    assign bus.m_tdata   = tdata;
    assign bus.m_tlast   = tlast;

endmodule

// File: tb/tb_sq_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_sq_burst_reader
// Directed bench for sq_burst_reader. A queue models the FWFT FIFO; expected
// beats go into a scoreboard queue when a request is issued and are popped
// by the stream monitor on every handshake. Inputs change 1 time unit after
// the rising edge, DUT outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sq_burst_reader;
    import sq_pkg::*;

    localparam int DW = 32;
    localparam int CW = 15;
    localparam int ML = 256;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic aclk = 1'b0;
    logic reset;
    logic busy, done, len_err;

    always #5 aclk = ~aclk;

    sq_burst_reader_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

    sq_burst_reader #(
        .DATA_WIDTH  (DW),
        .MAX_LEN     (ML),
        .COUNT_WIDTH (CW)
    ) dut (
        .aclk    (aclk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .len_err (len_err)
    );

    beat_t         exp_q[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] refill_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- stream / FIFO monitor (falling edge) ----------------
    int            cyc = 0;
    int            pop_cnt, hs_cnt, done_cnt, lenerr_cnt, tvalid_cnt, stall_cnt;
    int            first_pop, last_pop, first_hs, last_hs;
    logic          prev_stall = 1'b0, prev_last = 1'b0, prev_done = 1'b0, prev_reset = 1'b1;
    logic [DW-1:0] prev_data = '0;

    always @(negedge aclk) begin
        beat_t e;
        cyc++;
        if (bus.fifo_pop) begin
            if (pop_cnt == 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
            check("pop_not_empty", 64'(bus.fifo_empty), 64'(1'b0));
        end
        if (bus.m_tvalid) tvalid_cnt++;
        if (done) done_cnt++;
        if (len_err) begin
            lenerr_cnt++;
            check("len_err_with_done", 64'(done), 64'(1'b1));
        end
        if (prev_done) check("done_one_cycle", 64'(done), 64'(1'b0));
        if (prev_stall && !prev_reset) begin
            check("stall_tvalid", 64'(bus.m_tvalid), 64'(1'b1));
            check("stall_tdata",  64'(bus.m_tdata),  64'(prev_data));
            check("stall_tlast",  64'(bus.m_tlast),  64'(prev_last));
        end
        if (bus.m_tvalid && !bus.m_tready) begin
            stall_cnt++;
            check("pop_while_stalled", 64'(bus.fifo_pop), 64'(1'b0));
        end
        if (bus.m_tvalid && bus.m_tready) begin
            if (hs_cnt == 0) first_hs = cyc;
            last_hs = cyc;
            hs_cnt++;
            check("beat_expected", 64'(exp_q.size() != 0), 64'(1'b1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat_tdata", 64'(bus.m_tdata), 64'(e.data));
                check("beat_tlast", 64'(bus.m_tlast), 64'(e.last));
            end
        end
        prev_stall = bus.m_tvalid && !bus.m_tready;
        prev_data  = bus.m_tdata;
        prev_last  = bus.m_tlast;
        prev_done  = done;
        prev_reset = reset;
    end

    // ---------------- stimulus helpers ----------------
    logic pop_now, acc_now, done_now, busy_now;
    int   cnt_now;

    task automatic fifo_update();
        bus.data_count     = CW'(fifo_q.size());
        bus.fifo_empty     = (fifo_q.size() == 0);
        bus.data_from_fifo = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_update();
    endtask

    task automatic load_fifo(input logic [DW-1:0] base, input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
        fifo_update();
    endtask

    task automatic expect_burst(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{data: base + DW'(i), last: (i == n - 1)});
    endtask

    // One clock: sample at the falling edge, apply FIFO pop after the rise.
    task automatic tick();
        @(negedge aclk);
        pop_now  = bus.fifo_pop;
        acc_now  = bus.req_valid && bus.req_ready;
        done_now = done;
        busy_now = busy;
        cnt_now  = int'(bus.data_count);
        @(posedge aclk);
        #1;
        if (pop_now && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_update();
    endtask

    task automatic clear_stats();
        pop_cnt = 0; hs_cnt = 0; done_cnt = 0; lenerr_cnt = 0; tvalid_cnt = 0; stall_cnt = 0;
        first_pop = 0; last_pop = 0; first_hs = 0; last_hs = 0;
    endtask

    task automatic send_req(input int len);
        logic acc = 1'b0;
        bus.req_len   = SQ_LEN_WIDTH'(len);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 10 && !acc; i++) begin
            tick();
            acc = acc_now;
        end
        bus.req_valid = 1'b0;
        check("req_accepted", 64'(acc), 64'(1'b1));
    endtask

    // Runs until done; optional refill every refill_every cycles and an
    // m_tready pattern of 1,0,0 repeating when toggle is set.
    task automatic wait_done(input int budget, input int need, input int refill_every, input logic toggle);
        logic seen = 1'b0, busy_low = 1'b0, popped = 1'b0, enough = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (toggle) bus.m_tready = ((i % 3) == 0);
            tick();
            if (!busy_now) busy_low = 1'b1;
            if (done_now) seen = 1'b1;
            if (!popped) begin
                if (pop_now) begin
                    popped = 1'b1;
                    check("pop_after_count_ok", 64'(enough), 64'(1'b1));
                end
                if (cnt_now >= need) enough = 1'b1;
            end
            if (refill_every != 0 && (i % refill_every) == refill_every - 1 && refill_q.size() != 0)
                push_word(refill_q.pop_front());
        end
        bus.m_tready = 1'b1;
        check("done_seen", 64'(seen), 64'(1'b1));
        check("busy_held", 64'(busy_low), 64'(1'b0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_len   = '0;
        bus.m_tready  = 1'b0;
        clear_stats();
        fifo_update();
        tick();
        tick();
        check("rst_req_ready_low", 64'(bus.req_ready), 64'(1'b0));
        reset = 1'b0;
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'(1'b1));
        check("rst_tvalid",    64'(bus.m_tvalid),  64'(1'b0));
        check("rst_tlast",     64'(bus.m_tlast),   64'(1'b0));
        check("rst_tdata",     64'(bus.m_tdata),   64'(0));
        check("rst_fifo_pop",  64'(bus.fifo_pop),  64'(1'b0));
        check("rst_busy",      64'(busy),          64'(1'b0));
        check("rst_done",      64'(done),          64'(1'b0));
        check("rst_len_err",   64'(len_err),       64'(1'b0));

        // Basic burst: 8 words preloaded, len=4, ready held high.
        bus.m_tready = 1'b1;
        load_fifo(32'h10, 8);
        clear_stats();
        expect_burst(32'h10, 4);
        send_req(4);
        wait_done(30, 4, 0, 1'b0);
        check("a_pops",        64'(pop_cnt),             64'(4));
        check("a_pops_b2b",    64'(last_pop - first_pop), 64'(3));
        check("a_beats_b2b",   64'(last_hs - first_hs),   64'(3));
        check("a_done_once",   64'(done_cnt),            64'(1));
        check("a_no_len_err",  64'(lenerr_cnt),          64'(0));
        check("a_data_count",  64'(bus.data_count),      64'(4));
        check("a_sb_empty",    64'(exp_q.size()),        64'(0));

        // Starved FIFO: 2 words, len=4, one refill word every 3 cycles.
        load_fifo(32'h20, 2);
        refill_q.delete();
        refill_q.push_back(32'h22);
        refill_q.push_back(32'h23);
        clear_stats();
        expect_burst(32'h20, 4);
        send_req(4);
        wait_done(60, 4, 3, 1'b0);
        check("b_pops",        64'(pop_cnt),             64'(4));
        check("b_pops_b2b",    64'(last_pop - first_pop), 64'(3));
        check("b_done_once",   64'(done_cnt),            64'(1));
        check("b_sb_empty",    64'(exp_q.size()),        64'(0));

        // Back-pressure: ready pattern 1,0,0 repeating.
        load_fifo(32'h30, 6);
        clear_stats();
        expect_burst(32'h30, 4);
        send_req(4);
        wait_done(60, 4, 0, 1'b1);
        check("c_handshakes",  64'(hs_cnt),              64'(4));
        check("c_pops",        64'(pop_cnt),             64'(4));
        check("c_stalled",     64'(stall_cnt != 0),      64'(1'b1));
        check("c_sb_empty",    64'(exp_q.size()),        64'(0));

        // Illegal lengths: 0 and 300.
        clear_stats();
        send_req(0);
        wait_done(10, 0, 0, 1'b0);
        check("d0_pops",       64'(pop_cnt),    64'(0));
        check("d0_tvalid",     64'(tvalid_cnt), 64'(0));
        check("d0_done",       64'(done_cnt),   64'(1));
        check("d0_len_err",    64'(lenerr_cnt), 64'(1));
        clear_stats();
        send_req(300);
        wait_done(10, 300, 0, 1'b0);
        check("d300_pops",     64'(pop_cnt),    64'(0));
        check("d300_tvalid",   64'(tvalid_cnt), 64'(0));
        check("d300_done",     64'(done_cnt),   64'(1));
        check("d300_len_err",  64'(lenerr_cnt), 64'(1));

        // Reset while beat 2 of a len=8 burst is presented.
        load_fifo(32'h40, 12);
        clear_stats();
        expect_burst(32'h40, 8);
        send_req(8);
        begin
            logic found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                tick();
                found = (hs_cnt == 1) && bus.m_tvalid;
            end
            check("e_beat2_reached", 64'(found), 64'(1'b1));
        end
        check("e_beat2_tdata", 64'(bus.m_tdata), 64'(32'h41));
        reset = 1'b1;
        #1;
        check("e_rst_req_ready_low", 64'(bus.req_ready), 64'(1'b0));
        check("e_rst_no_pop",        64'(bus.fifo_pop),  64'(1'b0));
        tick();
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("e_tvalid",    64'(bus.m_tvalid),  64'(1'b0));
        check("e_tlast",     64'(bus.m_tlast),   64'(1'b0));
        check("e_tdata",     64'(bus.m_tdata),   64'(0));
        check("e_busy",      64'(busy),          64'(1'b0));
        check("e_done",      64'(done),          64'(1'b0));
        check("e_len_err",   64'(len_err),       64'(1'b0));
        check("e_req_ready", 64'(bus.req_ready), 64'(1'b1));
        clear_stats();
        exp_q.push_back('{data: fifo_q[0], last: 1'b0});
        exp_q.push_back('{data: fifo_q[1], last: 1'b1});
        send_req(2);
        wait_done(20, 2, 0, 1'b0);
        check("e_handshakes", 64'(hs_cnt),       64'(2));
        check("e_pops",       64'(pop_cnt),      64'(2));
        check("e_sb_empty",   64'(exp_q.size()), 64'(0));

        // Maximum burst: 256 words, ready high.
        load_fifo(32'h1000, 256);
        clear_stats();
        expect_burst(32'h1000, 256);
        send_req(256);
        wait_done(400, 256, 0, 1'b0);
        check("f_pops",       64'(pop_cnt),             64'(256));
        check("f_pops_b2b",   64'(last_pop - first_pop), 64'(255));
        check("f_beats",      64'(hs_cnt),              64'(256));
        check("f_beats_b2b",  64'(last_hs - first_hs),   64'(255));
        check("f_sb_empty",   64'(exp_q.size()),        64'(0));
        check("f_fifo_empty", 64'(bus.fifo_empty),      64'(1'b1));
        check("f_done_once",  64'(done_cnt),            64'(1));

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
